// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: stage-action encoding,
// stall polarity, default widths and the NOP register address.
package pipe_stage_reg_pkg;

  typedef enum logic [3:0] {
    ACT_ADV   = 4'b0001,
    ACT_HOLD  = 4'b0010,
    ACT_BUB   = 4'b0100,
    ACT_FLUSH = 4'b1000
  } act_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int DEF_STAGE_IDX = 3;
  localparam int DEF_STALL_W   = 6;
  localparam int DEF_NUM_WB    = 1;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_SCR_W     = 64;
  localparam int DEF_CNT_W     = 2;
  localparam int DEF_PERF_W    = 16;

  localparam logic [4:0] NOP_REG_ADDR = 5'd0;

endpackage

// File: rtl/pipe_stage_reg_ctrl.sv
// Decodes the core stall vector and flush into a one-hot stage action.
// Priority: flush, then bubble (s=1,d=0), then hold (s=1,d=1), else advance.
module pipe_stage_reg_ctrl
  import pipe_stage_reg_pkg::*;
#(
  parameter int STAGE_IDX = DEF_STAGE_IDX,
  parameter int STALL_W   = DEF_STALL_W
) (
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  output act_e               act
);

  logic s;
  logic d;
  logic unused_stall;

  assign s = stall[STAGE_IDX];
  assign d = stall[STAGE_IDX+1];
  // Only two bits of the vector matter to this stage.
  assign unused_stall = ^stall;

  always_comb begin
    act = ACT_ADV;
    if (flush)
      act = ACT_FLUSH;
    else if (s == STOP && d == NO_STOP)
      act = ACT_BUB;
    else if (s == STOP && d == STOP)
      act = ACT_HOLD;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush handling and scratch loop-back.
// Optional perf counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int STAGE_IDX = DEF_STAGE_IDX,
  parameter int STALL_W   = DEF_STALL_W,
  parameter int NUM_WB    = DEF_NUM_WB,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SCR_W     = DEF_SCR_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PERF_W    = DEF_PERF_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [NUM_WB*ADDR_W-1:0] in_wd,
  input  logic [NUM_WB-1:0]        in_wreg,
  input  logic [NUM_WB*DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0]        in_hi,
  input  logic [DATA_W-1:0]        in_lo,
  input  logic                     in_whilo,
  input  logic [SCR_W-1:0]         scr_i,
  input  logic [CNT_W-1:0]         cnt_i,
  output logic                     out_valid,
  output logic [NUM_WB*ADDR_W-1:0] out_wd,
  output logic [NUM_WB-1:0]        out_wreg,
  output logic [NUM_WB*DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0]        out_hi,
  output logic [DATA_W-1:0]        out_lo,
  output logic                     out_whilo,
  output logic [SCR_W-1:0]         scr_o,
  output logic [CNT_W-1:0]         cnt_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_W-1:0]        perf_adv,
  output logic [PERF_W-1:0]        perf_bub,
  output logic [PERF_W-1:0]        perf_hold
`endif
);

  localparam logic [NUM_WB*ADDR_W-1:0] NOP_WD = {NUM_WB{ADDR_W'(NOP_REG_ADDR)}};

  act_e act;

  pipe_stage_reg_ctrl #(
    .STAGE_IDX (STAGE_IDX),
    .STALL_W   (STALL_W)
  ) u_ctrl (
    .stall (stall),
    .flush (flush),
    .act   (act)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_wd    <= NOP_WD;
      out_wreg  <= '0;
      out_wdata <= '0;
      out_hi    <= '0;
      out_lo    <= '0;
      out_whilo <= 1'b0;
      scr_o     <= '0;
      cnt_o     <= '0;
    end else begin
      unique case (act)
        ACT_FLUSH: begin
          out_valid <= 1'b0;
          out_wd    <= NOP_WD;
          out_wreg  <= '0;
          out_wdata <= '0;
          out_hi    <= '0;
          out_lo    <= '0;
          out_whilo <= 1'b0;
          scr_o     <= '0;
          cnt_o     <= '0;
        end
        ACT_BUB: begin
          // Downstream drains a NOP while the stalled producer keeps its partial result.
          out_valid <= 1'b0;
          out_wd    <= NOP_WD;
          out_wreg  <= '0;
          out_wdata <= '0;
          out_hi    <= '0;
          out_lo    <= '0;
          out_whilo <= 1'b0;
          scr_o     <= scr_i;
          cnt_o     <= cnt_i;
        end
        ACT_HOLD: begin
        end
        default: begin
          out_valid <= in_valid;
          out_wd    <= in_wd;
          out_wreg  <= in_wreg & {NUM_WB{in_valid}};
          out_wdata <= in_wdata;
          out_hi    <= in_hi;
          out_lo    <= in_lo;
          out_whilo <= in_whilo & in_valid;
          scr_o     <= '0;
          cnt_o     <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  if (PERF_W > 0) begin : g_perf
    always_ff @(posedge clk) begin
      if (rst) begin
        perf_adv  <= '0;
        perf_bub  <= '0;
        perf_hold <= '0;
      end else begin
        if (act == ACT_ADV && in_valid && perf_adv != '1)
          perf_adv <= perf_adv + PERF_W'(1);
        if (act == ACT_BUB && perf_bub != '1)
          perf_bub <= perf_bub + PERF_W'(1);
        if (act == ACT_HOLD && perf_hold != '1)
          perf_hold <= perf_hold + PERF_W'(1);
      end
    end
  end
`else
  // Perf counters compiled out; the port list omits them.
`endif

  // Stalls only propagate upstream, so a running stage never sees its consumer stopped.
  illegal_stall_a : assert property (@(posedge clk) disable iff (rst)
    !(stall[STAGE_IDX] == NO_STOP && stall[STAGE_IDX+1] == STOP));

endmodule
